// File: rtl/bsg_cycle_counter.sv
// Free-running cycle counter with a loadable override.
//
// Increments by one on every rising clock edge. When load_i is high the
// counter takes val_i instead, so a caller can jump to an arbitrary value
// (for example just below the wrap point).
//
// Ports:
//   clk_i    - clock
//   reset_i  - asynchronous active-high reset, clears the count to 0
//   load_i   - when high, ctr_o takes val_i on the next edge
//   val_i    - value loaded when load_i is high
//   ctr_o    - current count
module bsg_cycle_counter #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [width_p-1:0] val_i,
    output logic [width_p-1:0] ctr_o
);

    logic [width_p-1:0] ctr_reg;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ctr_reg <= '0;
        end else if (load_i) begin
            ctr_reg <= val_i;
        end else begin
            ctr_reg <= ctr_reg + 1'b1;
        end
    end

    assign ctr_o = ctr_reg;

endmodule

// File: rtl/bsg_cycle_interval_meter.sv
// Measures the number of cycles between a start_i pulse and a stop_i pulse
// by sampling an external free-running counter at both events.
//
// Ports:
//   clk_i           - clock, all state updates on the rising edge
//   reset_i         - asynchronous active-high reset
//   ctr_i           - free-running cycle count, sampled at start/stop
//   start_i         - pulse that begins (or restarts) an interval
//   stop_i          - pulse that ends an interval
//   v_o             - delta_o is valid (held until accepted)
//   delta_o         - measured interval, modulo 2^width_p
//   ready_i         - consumer accepts delta_o when v_o & ready_i
//   busy_o          - a measurement is in progress
//   dropped_o       - sticky: at least one start_i pulse was lost
//   clear_dropped_i - clears dropped_o (a coincident new drop wins)
module bsg_cycle_interval_meter #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] ctr_i,
    input  logic               start_i,
    input  logic               stop_i,
    output logic               v_o,
    output logic [width_p-1:0] delta_o,
    input  logic               ready_i,
    output logic               busy_o,
    output logic               dropped_o,
    input  logic               clear_dropped_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [width_p-1:0] start_reg, start_next;
    logic [width_p-1:0] delta_reg, delta_next;
    logic               dropped_reg, dropped_next;
    logic               v_reg, busy_reg;
    logic               drop_set;

    always_comb begin
        state_next = state_reg;
        start_next = start_reg;
        delta_next = delta_reg;
        drop_set   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // stop_i has nothing to end here and is ignored
                if (start_i) begin
                    start_next = ctr_i;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    // Modular subtraction gives the right interval across wrap
                    delta_next = ctr_i - start_reg;
                    state_next = DONE;
                    drop_set   = start_i;
                end else if (start_i) begin
                    start_next = ctr_i;
                end
            end
            DONE: begin
                if (ready_i) begin
                    // A start coinciding with the handshake is not lost
                    if (start_i) begin
                        start_next = ctr_i;
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    drop_set = start_i;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (drop_set) begin
            dropped_next = 1'b1;
        end else if (clear_dropped_i) begin
            dropped_next = 1'b0;
        end else begin
            dropped_next = dropped_reg;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg   <= IDLE;
            start_reg   <= '0;
            delta_reg   <= '0;
            dropped_reg <= 1'b0;
            v_reg       <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            start_reg   <= start_next;
            delta_reg   <= delta_next;
            dropped_reg <= dropped_next;
            // Flag flops track the next state so they mirror the state exactly
            v_reg       <= (state_next == DONE);
            busy_reg    <= (state_next == RUN);
        end
    end

    assign v_o       = v_reg;
    assign busy_o    = busy_reg;
    assign delta_o   = delta_reg;
    assign dropped_o = dropped_reg;

endmodule
